// File: rtl/ddr3_port_arbiter.sv
// rtl/ddr3_port_arbiter.sv - two-port round-robin arbiter in front of a single-line DDR3 controller port
// Level strobes with an enforced low gap, shared read buffer, sticky hang detection.
module ddr3_port_arbiter #(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 65535
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  req0_addr_i,
    input  logic [255:0] req0_data_i,
    input  logic         req0_rd_i,
    input  logic         req0_we_i,
    output logic         req0_ack_o,
    input  logic [31:0]  req1_addr_i,
    input  logic [255:0] req1_data_i,
    input  logic         req1_rd_i,
    input  logic         req1_we_i,
    output logic         req1_ack_o,
    output logic [255:0] rdata_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    output logic         mem_rd_o,
    output logic         mem_we_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic         timeout_o,
    output logic [15:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [15:0] GAP_W     = 16'(GAP_CYCLES);
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t        state;
    state_t        state_nx;
    logic          last_grant;
    logic [15:0]   gap_cnt;
    logic [15:0]   to_cnt;

    logic          pend0;
    logic          pend1;
    logic          winner;
    logic          do_grant;
    logic          do_done;
    logic          do_timeout;
    logic [31:0]   sel_addr;
    logic [255:0]  sel_data;
    logic          sel_rd;
    logic          sel_we;

    assign pend0   = req0_rd_i | req0_we_i;
    assign pend1   = req1_rd_i | req1_we_i;
    assign state_o = {14'd0, state};

    // Round-robin only matters on contention; a lone requester always wins.
    always_comb begin
        winner = 1'b0;
        if (pend0 && pend1) begin
            winner = ~last_grant;
        end else begin
            winner = pend1;
        end
        sel_addr = winner ? req1_addr_i : req0_addr_i;
        sel_data = winner ? req1_data_i : req0_data_i;
        sel_rd   = winner ? req1_rd_i   : req0_rd_i;
        sel_we   = winner ? req1_we_i   : req0_we_i;
    end

    always_comb begin
        state_nx   = state;
        do_grant   = 1'b0;
        do_done    = 1'b0;
        do_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (pend0 || pend1) begin
                    do_grant = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                // A real ack on the limit cycle wins over the timeout.
                if (mem_ack_i) begin
                    do_done  = 1'b1;
                    state_nx = GAP;
                end else if (to_cnt == TIMEOUT_W) begin
                    do_done    = 1'b1;
                    do_timeout = 1'b1;
                    state_nx   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt <= 16'd1) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            gap_cnt    <= 16'd0;
            to_cnt     <= 16'd0;
            mem_addr_o <= 32'd0;
            mem_data_o <= 256'd0;
            mem_rd_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            rdata_o    <= 256'd0;
            req0_ack_o <= 1'b0;
            req1_ack_o <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            req0_ack_o <= 1'b0;
            req1_ack_o <= 1'b0;

            if (do_grant) begin
                mem_addr_o <= sel_addr & ~32'h0000_001F;
                mem_data_o <= sel_data;
                mem_rd_o   <= sel_rd;
                mem_we_o   <= ~sel_rd & sel_we;
                last_grant <= winner;
                to_cnt     <= 16'd0;
            end

            if (state == ISSUE && !do_done && to_cnt != 16'hFFFF) begin
                to_cnt <= to_cnt + 16'd1;
            end

            if (do_done) begin
                mem_rd_o <= 1'b0;
                mem_we_o <= 1'b0;
                gap_cnt  <= GAP_W;
                if (last_grant) begin
                    req1_ack_o <= 1'b1;
                end else begin
                    req0_ack_o <= 1'b1;
                end
                if (mem_rd_o) begin
                    rdata_o <= do_timeout ? 256'd0 : mem_data_i;
                end
                if (do_timeout) begin
                    timeout_o <= 1'b1;
                end
            end

            if (state == GAP) begin
                gap_cnt <= gap_cnt - 16'd1;
            end
        end
    end

endmodule

// File: doc/ddr3_port_arbiter.md
# ddr3_port_arbiter

Two-port, round-robin arbiter that shares the single-line DDR3 controller port (32-bit byte address, 256-bit line data, edge-triggered `we_i`/`rd_i`, one-cycle `ack_o` pulse) between two requesters, port 0 for the instruction cache and port 1 for the data cache. It sits in the `clk` domain between the caches and the DDR3 controller. It serialises requests, registers the winner's command, drives level strobes with a guaranteed low gap between them, returns read data, and flags controller hangs with a timeout.

## Interface
- `GAP_CYCLES`, default 2: cycles the strobes are held low after each ack. Must be ≥1.
- `TIMEOUT`, default 65535: maximum cycles spent waiting for `mem_ack_i` before the transaction is aborted.
- `clk` in 1: system clock. All logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_addr_i`, `req1_addr_i` in 32: byte address. Bits [4:0] are ignored and forced to 0 downstream.
- `req0_data_i`, `req1_data_i` in 256: write line.
- `req0_rd_i`, `req1_rd_i` in 1: read request. This is a level; the requester holds it until its ack.
- `req0_we_i`, `req1_we_i` in 1: write request. This is a level; the requester holds it until its ack.
- `req0_ack_o`, `req1_ack_o` out 1: one-cycle completion pulse.
- `rdata_o` out 256: shared read-data buffer for both ports.
- `mem_addr_o` out 32: to the controller's `addr_i`.
- `mem_data_o` out 256: to the controller's `data_i`.
- `mem_rd_o` out 1: to the controller's `rd_i`.
- `mem_we_o` out 1: to the controller's `we_i`.
- `mem_data_i` in 256: from the controller's `data_o`.
- `mem_ack_i` in 1: from the controller's `ack_o`, a one-cycle pulse.
- `timeout_o` out 1: sticky error flag. Cleared only by `rst`.
- `state_o` out 16: current state, zero-extended, for debug display.

## Operation
- **States:** IDLE=0, ISSUE=1, GAP=2.
- **Reset values:** all outputs 0. State is IDLE, `last_grant` is 1 (so port 0 wins first), and the gap and timeout counters are 0.
- **A port is pending** when its `rd_i` or `we_i` is high. If both are high on one port, only the read is performed; this is a protocol violation and needs no other handling.
- **IDLE:**
  - No pending ports: stay in IDLE.
  - One port pending: grant it.
  - Both ports pending: grant the port ≠ `last_grant`.
  - On grant:
    - Latch `mem_addr_o` = {addr[31:5], 5'b0}.
    - Latch `mem_data_o` = the grantee's data_i.
    - Set `mem_rd_o` or `mem_we_o` to 1.
    - Set `last_grant` to the grantee and clear the timeout counter.
    - Go to ISSUE.
- **ISSUE:**
  - The selected strobe stays high and address/data are held stable. Requester inputs are not re-sampled.
  - On `mem_ack_i`:
    - If reading, `rdata_o` <= `mem_data_i`. On a write, `rdata_o` keeps its previous value.
    - Grantee's `ack_o` <= 1 for one cycle.
    - Both strobes <= 0.
    - Load the gap counter with `GAP_CYCLES`.
    - Go to GAP.
  - Else, when the counter reaches `TIMEOUT`:
    - `timeout_o` <= 1.
    - Grantee's `ack_o` <= 1.
    - `rdata_o` <= 0 on a read.
    - Strobes <= 0; go to GAP.
  - Otherwise, increment the counter. The counter is 16 bits and saturates; it never wraps.
- **GAP:**
  - Strobes stay low, so the controller sees a falling edge and the next rising edge is valid.
  - Decrement the counter. At 1, go to IDLE.
  - All requests are ignored in GAP, including a late-dropping grantee.
- **`rdata_o`** holds its value until the next read completes. It is valid during the ack cycle and after it.
- **`mem_ack_i` outside ISSUE** is ignored.
- **Reset asserted mid-transaction:** returns immediately to reset values. No ack is issued for the aborted transaction.

## Timing
- **Request to strobe:** a request sampled in IDLE at edge E0 gives `mem_*` outputs valid and strobe high from E0 (registered). Pending status is combinational from the inputs.
- **Ack:** `mem_ack_i` high in the cycle before edge Ea gives `reqN_ack_o` and `rdata_o` valid in the cycle after Ea, with strobes low from Ea.
- **Latency:** request-to-ack is controller latency + 2 cycles.
- **Back-to-back issue:** minimum spacing between strobe rising edges is `GAP_CYCLES` + 2 cycles after the ack.
- **Requester obligation:** drop rd/we in the cycle after its ack. A request still high on return to IDLE is treated as a new request.
- **Simultaneous new requests in IDLE:** exactly one grant. The loser stays pending and wins the next IDLE.
- **Single active port:** may be granted consecutively, since round-robin applies only on contention.
- **Ack on the timeout-reach cycle:** counts as a normal ack; `timeout_o` is not set.

## Test plan
- **Reset then single read:** reset, then port 0 reads 0x0000_1234. Expect `mem_addr_o`=0x0000_1220 and `mem_rd_o` high until the ack. With `mem_data_i`=256'hA5…A5, expect a `req0_ack_o` pulse of exactly 1 cycle and `rdata_o`=A5…A5. Strobe low for 2 cycles.
- **Contention round-robin:** both ports hold reads continuously, re-asserting after each ack. Expect grant order 0,1,0,1 over 4 transactions and no strobe overlap.
- **Write path:** port 1 writes 0x0000_0040 with data 256'h1…. Expect `mem_we_o` high and `mem_data_o`=1…. Expect `req1_ack_o` on ack and `rdata_o` unchanged.
- **Timeout:** with `TIMEOUT`=8, the model never acks. Expect `timeout_o`=1 and `req0_ack_o` pulsing 9 cycles after the strobe rises, with `rdata_o`=0. The next request still completes normally.
- **Reset mid-ISSUE:** assert `rst` while `mem_rd_o` is high. Expect all outputs 0 asynchronously, no ack, and port 0 winning the next contention.
- **Stray ack:** pulse `mem_ack_i` in IDLE and in GAP. Expect no acks and no state change.
